// File: rtl/sprite_pkg.sv
// Shared types for the procedural circle sprite engine.
package sprite_pkg;

    // Sprite motion mode; changes only at the start of vertical blank.
    typedef enum logic {
        S_STATIC = 1'b0,
        S_BOUNCE = 1'b1
    } spr_state_t;

    // RGB332 colour word: rrr_ggg_bb.
    typedef logic [7:0] rgb332_t;

endpackage

// File: rtl/circle_mask.sv
// Two-stage circle coverage test for a SIZE x SIZE box.
// Takes in-box pixel coordinates, and produces a registered hit after two clocks.
// The test is done in doubled coordinates, so the centre sits on an integer.
// A filled disc needs d2 <= SIZE^2. A ring of RING_W pixels also needs
// d2 >= (SIZE-2*RING_W)^2.
module circle_mask #(
    parameter int SIZE   = 64,
    parameter int RING_W = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [$clog2(SIZE)-1:0]   col,
    input  logic [$clog2(SIZE)-1:0]   row,
    input  logic                      valid,
    input  logic                      ring,
    output logic                      hit
);
    localparam int AW   = $clog2(SIZE);
    localparam int DW   = AW + 2;
    localparam int D2_W = 2 * DW;
    localparam logic [D2_W-1:0] OUTER = D2_W'(SIZE * SIZE);
    localparam logic [D2_W-1:0] INNER = D2_W'((SIZE - 2 * RING_W) * (SIZE - 2 * RING_W));

    logic signed [DW-1:0]   dx, dy;
    logic signed [D2_W-1:0] dx2, dy2;
    logic [D2_W-1:0]        d2_c, d2_q;
    logic                   valid_q, ring_q;

    // Signed offsets from the doubled centre, and the squared distance
    always_comb begin
        dx   = $signed({1'b0, col, 1'b0}) - $signed(DW'(SIZE - 1));
        dy   = $signed({1'b0, row, 1'b0}) - $signed(DW'(SIZE - 1));
        dx2  = D2_W'(dx) * D2_W'(dx);
        dy2  = D2_W'(dy) * D2_W'(dy);
        d2_c = dx2 + dy2;
    end

    // S2: register the squared distance next to its qualifiers
    // NOTE: clocked state uses non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d2_q    <= '0;
            valid_q <= 1'b0;
            ring_q  <= 1'b0;
        end else begin
            d2_q    <= d2_c;
            valid_q <= valid;
            ring_q  <= ring;
        end
    end

    // S3: compare against the outer radius, and the inner radius in ring mode
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit <= 1'b0;
        end else begin
            hit <= valid_q && (d2_q <= OUTER) && (!ring_q || (d2_q >= INNER));
        end
    end

endmodule

// File: rtl/sprite_circle_engine.sv
// Procedural circle sprite. It sits between the VGA timing generator and the RGB mux.
// Position, ring mode and colour are shadowed, and they change only on frame_start_i.
// In bounce mode the sprite moves by its velocity once per frame. It reflects off
// the visible-area edges. Every output has exactly 3 cycles of latency from the raster inputs.
module sprite_circle_engine
    import sprite_pkg::*;
#(
    parameter int SIZE    = 64,
    parameter int RING_W  = 4,
    parameter int X_W     = 10,
    parameter int Y_W     = 10,
    parameter int H_RES   = 640,
    parameter int V_RES   = 480,
    parameter int COLOR_W = 8,
    parameter int VEL_W   = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [X_W-1:0]     hcount_i,
    input  logic [Y_W-1:0]     vcount_i,
    input  logic               de_i,
    input  logic               hsync_i,
    input  logic               vsync_i,
    input  logic               frame_start_i,
    input  logic [X_W-1:0]     pos_x_i,
    input  logic [Y_W-1:0]     pos_y_i,
    input  logic [VEL_W-1:0]   vel_x_i,
    input  logic [VEL_W-1:0]   vel_y_i,
    input  logic               bounce_i,
    input  logic               ring_i,
    input  logic [COLOR_W-1:0] color_i,
    output logic               pix_on_o,
    output logic [COLOR_W-1:0] pix_rgb_o,
    output logic               de_o,
    output logic               hsync_o,
    output logic               vsync_o
);
    localparam int AW   = $clog2(SIZE);
    localparam int PX_W = X_W + 2;  // headroom: pos + vel is clamped before truncation
    localparam int PY_W = Y_W + 2;

    spr_state_t             state_q, state_d;
    logic [X_W-1:0]         pos_x_q, pos_x_d;
    logic [Y_W-1:0]         pos_y_q, pos_y_d;
    logic [VEL_W-1:0]       vel_x_q, vel_x_d, vel_y_q, vel_y_d;
    logic                   ring_q;
    logic [COLOR_W-1:0]     color_q;
    logic signed [PX_W-1:0] nx;
    logic signed [PY_W-1:0] ny;

    // FSM state register, advanced only at the start of vertical blank
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)             state_q <= S_STATIC;
        else if (frame_start_i) state_q <= state_d;
    end

    // Next state follows the bounce request
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_STATIC: if (bounce_i)  state_d = S_BOUNCE;
            S_BOUNCE: if (!bounce_i) state_d = S_STATIC;
            default:                 state_d = S_STATIC;
        endcase
    end

    // Next position/velocity: follow the inputs, or step and reflect at the edges
    // NOTE: every combinational output gets a default first, so no path infers a latch.
    always_comb begin
        pos_x_d = pos_x_i;
        pos_y_d = pos_y_i;
        vel_x_d = vel_x_q;
        vel_y_d = vel_y_q;
        nx      = $signed({2'b00, pos_x_q}) + PX_W'($signed(vel_x_q));
        ny      = $signed({2'b00, pos_y_q}) + PY_W'($signed(vel_y_q));
        case (state_q)
            S_STATIC: begin
                if (bounce_i) begin
                    vel_x_d = vel_x_i;
                    vel_y_d = vel_y_i;
                end
            end
            S_BOUNCE: begin
                if (bounce_i) begin
                    if (nx[PX_W-1]) begin
                        pos_x_d = '0;
                        vel_x_d = -vel_x_q;
                    end else if (nx > $signed(PX_W'(H_RES - SIZE))) begin
                        pos_x_d = X_W'(H_RES - SIZE);
                        vel_x_d = -vel_x_q;
                    end else begin
                        pos_x_d = nx[X_W-1:0];
                    end
                    if (ny[PY_W-1]) begin
                        pos_y_d = '0;
                        vel_y_d = -vel_y_q;
                    end else if (ny > $signed(PY_W'(V_RES - SIZE))) begin
                        pos_y_d = Y_W'(V_RES - SIZE);
                        vel_y_d = -vel_y_q;
                    end else begin
                        pos_y_d = ny[Y_W-1:0];
                    end
                end
            end
            default: ;
        endcase
    end

    // Shadow registers: no tearing, because they change only during blanking
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos_x_q <= '0;
            pos_y_q <= '0;
            vel_x_q <= '0;
            vel_y_q <= '0;
            ring_q  <= 1'b0;
            color_q <= '0;
        end else if (frame_start_i) begin
            pos_x_q <= pos_x_d;
            pos_y_q <= pos_y_d;
            vel_x_q <= vel_x_d;
            vel_y_q <= vel_y_d;
            ring_q  <= ring_i;
            color_q <= color_i;
        end
    end

    logic signed [X_W:0] col_c;
    logic signed [Y_W:0] row_c;
    logic                inbox_c;
    logic [AW-1:0]       col_s1, row_s1;
    logic                valid_s1;
    logic [2:0]          de_p, hs_p, vs_p;

    // S1 arithmetic: sprite-relative coordinates and the bounding-box test (no wrap)
    always_comb begin
        col_c   = $signed({1'b0, hcount_i}) - $signed({1'b0, pos_x_q});
        row_c   = $signed({1'b0, vcount_i}) - $signed({1'b0, pos_y_q});
        inbox_c = !col_c[X_W] && (col_c[X_W-1:0] < X_W'(SIZE)) &&
                  !row_c[Y_W] && (row_c[Y_W-1:0] < Y_W'(SIZE));
    end

    // S1 registers, plus a 3-deep delay of the sync/enable strobes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_s1   <= '0;
            row_s1   <= '0;
            valid_s1 <= 1'b0;
            de_p     <= '0;
            hs_p     <= '0;
            vs_p     <= '0;
        end else begin
            col_s1   <= col_c[AW-1:0];
            row_s1   <= row_c[AW-1:0];
            valid_s1 <= inbox_c && de_i;
            de_p     <= {de_p[1:0], de_i};
            hs_p     <= {hs_p[1:0], hsync_i};
            vs_p     <= {vs_p[1:0], vsync_i};
        end
    end

    circle_mask #(
        .SIZE   (SIZE),
        .RING_W (RING_W)
    ) u_mask (
        .clk   (clk),
        .rst_n (rst_n),
        .col   (col_s1),
        .row   (row_s1),
        .valid (valid_s1),
        .ring  (ring_q),
        .hit   (pix_on_o)
    );

    assign pix_rgb_o = pix_on_o ? color_q : '0;
    assign de_o      = de_p[2];
    assign hsync_o   = hs_p[2];
    assign vsync_o   = vs_p[2];

endmodule
